// File: rtl/ts_renderer_if.sv
// Renderer-side bundle: task handshake from the TS processor, DRAM word fetch
// port and line-buffer write port.
interface ts_renderer_if;
  logic        start;
  logic        tsr_go;
  logic [5:0]  tsr_addr;
  logic [8:0]  tsr_line;
  logic [7:0]  tsr_page;
  logic [8:0]  tsr_x;
  logic [2:0]  tsr_xs;
  logic        tsr_xf;
  logic [3:0]  tsr_pal;
  logic        tsr_rdy;
  logic [20:0] dram_addr;
  logic        dram_req;
  logic        dram_next;
  logic [15:0] dram_rdata;
  logic [8:0]  ts_waddr;
  logic [7:0]  ts_wdata;
  logic        ts_we;

  modport slave (
    input  start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
    input  dram_next, dram_rdata,
    output tsr_rdy, dram_addr, dram_req, ts_waddr, ts_wdata, ts_we
  );

  modport master (
    output start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
    output dram_next, dram_rdata,
    input  tsr_rdy, dram_addr, dram_req, ts_waddr, ts_wdata, ts_we
  );
endinterface

// File: rtl/ts_renderer.sv
// Tile/sprite renderer: fetches 4bpp graphics words for one strip task and
// writes palette-tagged, non-transparent pixels into the TS line buffer.
module ts_renderer (
  input  logic         clk,
  input  logic         rst,
  ts_renderer_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state;
  logic [5:0]  addr;
  logic [8:0]  line;
  logic [7:0]  page;
  logic [2:0]  xs;
  logic        xf;
  logic [3:0]  pal;
  logic [4:0]  w;
  logic [2:0]  pc;
  logic [15:0] shreg;
  logic [8:0]  x;

  logic [4:0]  w_tot, fw;
  logic [7:0]  page_sum;
  logic [6:0]  word_sel;
  logic        accept, fetch, done;

  assign w_tot    = {1'b0, xs, 1'b0} + 5'd2;
  assign fw       = xf ? (w_tot - 5'd1 - w) : w;
  assign page_sum = page + {5'b0, line[8:6]};
  assign word_sel = {addr, 1'b0} + {2'b0, fw};

  assign bus.dram_addr = {page_sum, line[5:0], word_sel};
  assign bus.dram_req  = (state == S_RUN) && (w < w_tot) && (pc <= 3'd1);
  assign bus.tsr_rdy   = (state == S_IDLE);

  // Current pixel is always the top nibble of the shift register.
  assign bus.ts_waddr = x;
  assign bus.ts_wdata = {pal, shreg[15:12]};
  assign bus.ts_we    = (pc != 3'd0) && (shreg[15:12] != 4'd0);

  assign accept = bus.tsr_go && bus.tsr_rdy;
  assign fetch  = bus.dram_req && bus.dram_next;
  // Drop to IDLE one cycle early so the last pixel overlaps the first rdy cycle,
  // which lets a back-to-back go start fetching with no bubble.
  assign done   = (state == S_RUN) && (w == w_tot) && (pc == 3'd2);

  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      state <= S_IDLE;
      w     <= 5'd0;
      pc    <= 3'd0;
      x     <= 9'd0;
      shreg <= 16'd0;
      pal   <= 4'd0;
    end else begin
      if (pc != 3'd0) begin
        x     <= x + 9'd1;
        shreg <= {shreg[11:0], 4'h0};
        pc    <= pc - 3'd1;
      end
      if (fetch) begin
        // Reorder nibbles so they leave MSB-first in display order.
        shreg <= xf ? {bus.dram_rdata[11:8], bus.dram_rdata[15:12],
                       bus.dram_rdata[3:0],  bus.dram_rdata[7:4]}
                    : {bus.dram_rdata[7:0],  bus.dram_rdata[15:8]};
        pc    <= 3'd4;
        w     <= w + 5'd1;
      end
      if (done)
        state <= S_IDLE;
      if (accept) begin
        state <= S_RUN;
        addr  <= bus.tsr_addr;
        line  <= bus.tsr_line;
        page  <= bus.tsr_page;
        xs    <= bus.tsr_xs;
        xf    <= bus.tsr_xf;
        pal   <= bus.tsr_pal;
        x     <= bus.tsr_x;
        w     <= 5'd0;
        pc    <= 3'd0;
      end
    end
  end
endmodule

// File: tb/tb_ts_renderer.sv
// Directed/randomized bench for ts_renderer: acts as the DRAM and task source,
// and compares fetch addresses and line-buffer writes with a strip-level model.
module tb_ts_renderer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ts_renderer_if bus();
  ts_renderer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] rd_words [16];
  logic [16:0] got   [$];
  logic [16:0] exp_w [$];
  logic [20:0] exp_a [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected fetch addresses (all W words) and the writes of the first nout words.
  task automatic build_model(input int pg, input int ln, input int ad, input int x0,
                             input int xs, input int xf, input int pal, input int nout);
    int nw, fw, a, n, pos;
    int nib [4];
    nw = (xs + 1) * 2;
    exp_a.delete();
    exp_w.delete();
    for (int k = 0; k < nw; k++) begin
      fw = xf ? (nw - 1 - k) : k;
      a  = (((pg + ln / 64) % 256) << 13) | ((ln % 64) << 7) | ((ad * 2 + fw) % 128);
      exp_a.push_back(21'(a));
    end
    for (int k = 0; k < nout; k++) begin
      nib[0] = (rd_words[k] >> 4) & 15;
      nib[1] = rd_words[k] & 15;
      nib[2] = (rd_words[k] >> 12) & 15;
      nib[3] = (rd_words[k] >> 8) & 15;
      for (int i = 0; i < 4; i++) begin
        n   = xf ? nib[3 - i] : nib[i];
        pos = (x0 + 4 * k + i) % 512;
        if (n != 0) exp_w.push_back({9'(pos), 4'(pal), 4'(n)});
      end
    end
  endtask

  // Issue one task from the current (rdy) cycle and serve it until done or aborted.
  task automatic run_task(input int pg, input int ln, input int ad, input int x0,
                          input int xs, input int xf, input int pal, input int max_stall,
                          input int abort_words, input bit use_rst, input bit hold_go);
    int nw, cyc, fk, stall, last_next;
    bit fin;
    nw = (xs + 1) * 2;
    build_model(pg, ln, ad, x0, xs, xf, pal, (abort_words < 0) ? nw : abort_words);
    got.delete();
    bus.tsr_go   = 1'b1;
    bus.tsr_page = 8'(pg);
    bus.tsr_line = 9'(ln);
    bus.tsr_addr = 6'(ad);
    bus.tsr_x    = 9'(x0);
    bus.tsr_xs   = 3'(xs);
    bus.tsr_xf   = 1'(xf);
    bus.tsr_pal  = 4'(pal);
    cyc = 0; fk = 0; stall = -1; last_next = 0; fin = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      bus.dram_next = 1'b0;
      if (!hold_go) bus.tsr_go = 1'b0;
      else begin
        bus.tsr_x    = 9'($urandom);
        bus.tsr_page = 8'($urandom);
        bus.tsr_pal  = 4'($urandom);
      end
      if (bus.ts_we) got.push_back({bus.ts_waddr, bus.ts_wdata});
      if (cyc == 1) chk("req_first_cycle", 32'(bus.dram_req), 32'd1);
      if (bus.tsr_rdy) begin
        fin = 1'b1;
        chk("fetch_count", 32'(fk), 32'(nw));
        chk("rdy_after_last_word", 32'(cyc), 32'(last_next + 4));
        if (max_stall == 0) chk("rdy_latency", 32'(cyc), 32'(4 * nw + 1));
      end else if (bus.dram_req) begin
        if (fk == abort_words) begin
          fin = 1'b1;
          if (use_rst) rst = 1'b1;
          else begin
            bus.start      = 1'b1;
            bus.dram_next  = 1'b1;
            bus.dram_rdata = rd_words[fk];
          end
          @(posedge clk); #1;
          bus.start = 1'b0;
          bus.dram_next = 1'b0;
          if (use_rst) begin @(posedge clk); #1; rst = 1'b0; end
          chk("abort_rdy", 32'(bus.tsr_rdy), 32'd1);
          chk("abort_req", 32'(bus.dram_req), 32'd0);
          chk("abort_we",  32'(bus.ts_we), 32'd0);
          for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.dram_next = $urandom_range(0, 1) == 1;
            if (bus.ts_we) got.push_back({bus.ts_waddr, bus.ts_wdata});
          end
          bus.dram_next = 1'b0;
        end else if (fk >= nw) begin
          chk("extra_fetch", 32'(fk), 32'(nw));
          fin = 1'b1;
        end else begin
          if (stall < 0) stall = $urandom_range(0, max_stall);
          if (stall == 0) begin
            chk("dram_addr", 32'(bus.dram_addr), 32'(exp_a[fk]));
            bus.dram_next  = 1'b1;
            bus.dram_rdata = rd_words[fk];
            fk++;
            last_next = cyc;
            stall = -1;
          end else begin
            stall--;
            bus.dram_rdata = 16'($urandom);
          end
        end
      end else begin
        // Strobes without a request must be ignored.
        bus.dram_next  = $urandom_range(0, 3) == 0;
        bus.dram_rdata = 16'($urandom);
      end
      if (cyc > 3000) begin
        chk("timeout", 32'd0, 32'd1);
        fin = 1'b1;
      end
    end
    chk("write_count", 32'(got.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      chk("write", 32'(got[i]), 32'(exp_w[i]));
  endtask

  task automatic rand_words();
    for (int i = 0; i < 16; i++) rd_words[i] = 16'($urandom);
  endtask

  initial begin
    bus.start = 1'b0; bus.tsr_go = 1'b0; bus.tsr_addr = '0; bus.tsr_line = '0;
    bus.tsr_page = '0; bus.tsr_x = '0; bus.tsr_xs = '0; bus.tsr_xf = 1'b0;
    bus.tsr_pal = '0; bus.dram_next = 1'b0; bus.dram_rdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy",   32'(bus.tsr_rdy), 32'd1);
    chk("reset_req",   32'(bus.dram_req), 32'd0);
    chk("reset_we",    32'(bus.ts_we), 32'd0);
    chk("reset_waddr", 32'(bus.ts_waddr), 32'd0);
    chk("reset_wdata", 32'(bus.ts_wdata), 32'd0);
    rst = 1'b0;

    // Unflipped 8-px tile
    rd_words[0] = 16'h2301; rd_words[1] = 16'h6745;
    run_task(8'h10, 9'h04A, 5, 100, 0, 0, 3, 0, -1, 1'b0, 1'b0);
    chk("lit_first_write", 32'(got.size() > 0 ? got[0] : 17'h0), 32'({9'd101, 8'h31}));
    chk("lit_write_count", 32'(got.size()), 32'd7);

    // Same tile flipped
    rd_words[0] = 16'h6745; rd_words[1] = 16'h2301;
    run_task(8'h10, 9'h04A, 5, 100, 0, 1, 3, 0, -1, 1'b0, 1'b0);
    chk("lit_flip_first", 32'(got.size() > 0 ? got[0] : 17'h0), 32'({9'd100, 8'h37}));
    chk("lit_flip_last", 32'(got.size() == 7 ? got[6] : 17'h0), 32'({9'd106, 8'h31}));

    // 64-px strip wrapping x and word field, with stalls
    rand_words();
    run_task($urandom_range(0, 255), $urandom_range(0, 511), 63, 500, 7, 0, 9, 5, -1, 1'b0, 1'b0);
    rand_words();
    run_task($urandom_range(0, 255), $urandom_range(0, 511), 63, 500, 7, 1, 6, 5, -1, 1'b0, 1'b0);

    // start abort after 2 of 4 words
    rand_words();
    run_task(8'h20, 9'h1FF, 10, 40, 1, 0, 5, 0, 2, 1'b0, 1'b0);

    // go held through RUN, then back-to-back task in the first rdy cycle
    rand_words();
    run_task(8'hFE, 9'h1C3, 12, 200, 2, 0, 7, 0, -1, 1'b0, 1'b1);
    rand_words();
    run_task(8'h33, 9'h021, 1, 300, 1, 1, 2, 0, -1, 1'b0, 1'b0);

    // reset held 2 cycles mid-task
    rand_words();
    run_task(8'h44, 9'h100, 30, 10, 3, 0, 4, 2, 1, 1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      rand_words();
      run_task($urandom_range(0, 255), $urandom_range(0, 511), $urandom_range(0, 63),
               $urandom_range(0, 511), $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 15), $urandom_range(0, 3), -1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
